// File: rtl/q_6_23_beh_counter.sv
// Modulo-MODULUS up-counter (default modulo-12) with count enable and terminal-count flag.
// Optional build macro Q_6_23_Y_GATED_EN: when defined, y is the Mealy carry-out
// (terminal count AND cnt_en) so counters can be ripple-cascaded; when undefined,
// y is the Moore terminal-count flag.
// MODULUS legal range 2..16; RESET_VALUE must be below MODULUS.
module q_6_23_beh_counter #(
  parameter int unsigned MODULUS     = 12,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       cnt_en,
  output logic [3:0] count,
  output logic       y
);

  localparam logic [3:0] MaxVal   = 4'(MODULUS - 1);
  localparam logic [3:0] ResetVal = 4'(RESET_VALUE);
  // Five bits so MODULUS == 16 does not alias to zero in the illegal-code compare.
  localparam logic [4:0] ModWide  = 5'(MODULUS);

  logic [3:0] count_q;
  logic [3:0] count_d;
  logic       illegal;
  logic       at_max;

  assign illegal = ({1'b0, count_q} >= ModWide);
  assign at_max  = (count_q == MaxVal);

  // Next-state: hold when disabled, wrap at the terminal value, recover illegal codes to 0.
  always_comb begin
    count_d = count_q;
    if (cnt_en) begin
      if (illegal || at_max) begin
        count_d = 4'd0;
      end else begin
        count_d = count_q + 4'd1;
      end
    end
  end

  // State register with synchronous active-low reset taking priority over enable.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      count_q <= ResetVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  // Illegal codes never equal MaxVal, so y is low for them in both builds.
`ifdef Q_6_23_Y_GATED_EN
  assign y = at_max & cnt_en;
`else
  assign y = at_max;
`endif

endmodule

// File: tb/tb_q_6_23_beh_counter.sv
// Self-checking bench for q_6_23_beh_counter: directed test-plan sequence, randomized
// enable/reset traffic against an arithmetic reference model, then illegal-code recovery.
module tb_q_6_23_beh_counter;

  localparam int unsigned Modulus    = 12;
  localparam int unsigned ResetValue = 0;

  logic       clk;
  logic       rstb;
  logic       cnt_en;
  logic [3:0] count;
  logic       y;

  int checks;
  int failures;
  int model;

  q_6_23_beh_counter #(
    .MODULUS    (Modulus),
    .RESET_VALUE(ResetValue)
  ) dut (
    .clk   (clk),
    .rstb  (rstb),
    .cnt_en(cnt_en),
    .count (count),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int exp_y(input int m, input logic en);
`ifdef Q_6_23_Y_GATED_EN
    return ((m == int'(Modulus) - 1) && en) ? 1 : 0;
`else
    return (m == int'(Modulus) - 1) ? 1 : 0;
`endif
  endfunction

  // Apply inputs at the falling edge, check outputs, then advance the model across one rising edge.
  task automatic step(input logic r, input logic en, input string tag);
    rstb   = r;
    cnt_en = en;
    #1;
    check_eq({tag, "_count"}, 8'(count), 8'(model));
    check_eq({tag, "_y"}, 8'(y), 8'(exp_y(model, en)));
    @(posedge clk);
    if (!r) model = ResetValue;
    else if (en) model = (model >= int'(Modulus)) ? 0 : (model + 1) % int'(Modulus);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstb     = 1'b0;
    cnt_en   = 1'b0;
    @(posedge clk);
    model = ResetValue;
    @(negedge clk);  // t = 10

    check_eq("reset_count", 8'(count), 8'd0);
    check_eq("reset_y", 8'(y), 8'd0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "idle");
    step(1'b1, 1'b1, "single_en");
    step(1'b1, 1'b0, "hold1");
    check_eq("after_single", 8'(count), 8'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "win");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "hold4");
    check_eq("held_4", 8'(count), 8'd4);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, "win2");
    check_eq("reached_6", 8'(count), 8'd6);
    step(1'b0, 1'b1, "rst_mid");
    check_eq("rst_beats_en", 8'(count), 8'd0);
    // Enabled from t=210: count 11 after edge 315, wraps at 325, 11 again at 435.
    for (int i = 0; i < 23; i++) step(1'b1, 1'b1, "run");
    check_eq("wrap_count", 8'(count), 8'd11);
    check_eq("wrap_y", 8'(y), 8'd1);
    // Deassert enable while at 11: Moore y stays, gated y drops; count holds.
    step(1'b1, 1'b0, "tc_hold");
    check_eq("tc_held", 8'(count), 8'd11);
    step(1'b1, 1'b1, "wrap_edge");
    check_eq("wrapped_zero", 8'(count), 8'd0);
    check_eq("wrapped_y", 8'(y), 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) != 0), ($urandom_range(2) != 0), "rand");
    end

    // Illegal code 13: hold while disabled with y low, recover to 0 on the next enabled edge.
    rstb   = 1'b1;
    cnt_en = 1'b0;
    force dut.count_q = 4'd13;
    @(posedge clk);
    @(negedge clk);
    release dut.count_q;
    model = 13;
    #1;
    check_eq("illegal_forced", 8'(count), 8'd13);
    step(1'b1, 1'b0, "illegal_hold");
    check_eq("illegal_held", 8'(count), 8'd13);
    step(1'b1, 1'b1, "illegal_recover");
    check_eq("illegal_to_zero", 8'(count), 8'd0);
    step(1'b1, 1'b1, "post_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
